// File: rtl/i2s_dac_tx.sv
// I2S master transmitter: pops one stereo word per frame from the sample FIFO and drives the WM8731 DAC.
// Build option UNDERRUN_REPEAT_EN: on underrun, resend the last popped word instead of silence.
module i2s_dac_tx #(
    parameter int DW       = 16,
    parameter int BCLK_DIV = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2*DW-1:0] fifo_data,
    input  logic            fifo_empty,
    output logic            fifo_rd,
    input  logic            mute,
    output logic            bclk,
    output logic            daclrc,
    output logic            dacdat,
    output logic            underrun
);
    localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BW = $clog2(2 * DW);
    localparam logic [CW-1:0] DIV_LAST = CW'(BCLK_DIV - 1);
    localparam logic [CW-1:0] DIV_ONE  = CW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * DW - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [BW-1:0] BIT_HALF = BW'(DW);

    logic [CW-1:0]   div_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [BW-1:0]   bit_nxt;
    logic [2*DW-1:0] sr;
    logic [2*DW-1:0] load_word;
    logic            fe;
    logic            frame_start;

`ifdef UNDERRUN_REPEAT_EN
    logic [2*DW-1:0] last_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_word <= '0;
        end else if (fifo_rd) begin
            last_word <= fifo_data;
        end
    end
`endif

    // Falling-edge event: the divider wraps while bclk is high, so bclk goes 1->0 this clk.
    always_comb begin
        fe          = bclk && (div_cnt == DIV_LAST);
        frame_start = fe && (bit_cnt == BIT_LAST);
        bit_nxt     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_ONE;
        // Pop/underrun strobes are combinational so they drop the instant reset rises.
        fifo_rd     = frame_start && !fifo_empty && !reset;
        underrun    = frame_start && fifo_empty && !reset;
        load_word   = '0;
        if (!fifo_empty) begin
            load_word = mute ? '0 : fifo_data;
        end else begin
`ifdef UNDERRUN_REPEAT_EN
            load_word = mute ? '0 : last_word;
`else
            load_word = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
        end
    end

    // Serial state moves only on FE; dacdat lags sr by one BCLK, giving the I2S one-bit delay.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= BIT_LAST;
            daclrc  <= 1'b0;
            dacdat  <= 1'b0;
            sr      <= '0;
        end else if (fe) begin
            bit_cnt <= bit_nxt;
            daclrc  <= (bit_nxt >= BIT_HALF);
            dacdat  <= sr[2*DW-1];
            sr      <= frame_start ? load_word : {sr[2*DW-2:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Self-checking bench for i2s_dac_tx: a time-indexed frame model predicts every output each clk.
module tb_i2s_dac_tx;
    localparam int DW  = 16;
    localparam int BD  = 4;
    localparam int FRM = 2 * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   fifo_data;
    logic          fifo_empty;
    logic          fifo_rd;
    logic          mute = 1'b0;
    logic          bclk;
    logic          daclrc;
    logic          dacdat;
    logic          underrun;
    logic [4:0]    outs;

    int n_assert = 0;
    int n_fail   = 0;

    i2s_dac_tx #(.DW(DW), .BCLK_DIV(BD)) dut (
        .clk(clk), .reset(reset), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_rd(fifo_rd), .mute(mute), .bclk(bclk), .daclrc(daclrc),
        .dacdat(dacdat), .underrun(underrun)
    );

    always #5 clk = ~clk;
    assign outs = {bclk, daclrc, dacdat, fifo_rd, underrun};

    // Sample FIFO feeding the DUT
    logic [31:0] mem [64];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_data  = mem[rd_ptr[5:0]];
    always @(posedge clk) if (fifo_rd) rd_ptr <= rd_ptr + 1;

    task automatic push(input logic [31:0] w);
        mem[wr_ptr[5:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    // Reference model: n = clks since reset release; frame k starts at clk 2*BD*(1+FRM*k).
    int          n = 0;
    logic [31:0] cur_word = '0;
    logic [31:0] prev_word = '0;
    logic [31:0] last_pop = '0;

    function automatic logic fs_at(input int m);
        return (m % (2 * BD) == 0) && (m > 0) && (((m / (2 * BD)) - 1) % FRM == 0);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n <= 0; cur_word <= '0; prev_word <= '0; last_pop <= '0;
        end else begin
            n <= n + 1;
            if (fs_at(n + 1)) begin
                prev_word <= cur_word;
                if (!fifo_empty) begin
                    cur_word <= mute ? 32'h0 : fifo_data;
                    last_pop <= fifo_data;
                end else begin
`ifdef UNDERRUN_REPEAT_EN
                    cur_word <= mute ? 32'h0 : last_pop;
`else
                    cur_word <= 32'h0;
`endif
                end
            end
        end
    end

    function automatic logic [4:0] exp_outs();
        int k, b;
        logic eb, el, ed, fs;
        eb = ((n / BD) % 2) == 1;
        k  = n / (2 * BD);
        el = 1'b0;
        ed = 1'b0;
        if (k > 0) begin
            b  = (k - 1) % FRM;
            el = (b >= DW);
            ed = (b == 0) ? prev_word[0] : cur_word[FRM - b];
        end
        fs = fs_at(n + 1) && !reset;
        return {eb, el, ed, fs && !fifo_empty, fs && fifo_empty};
    endfunction

    // Monitor: dacdat at each bclk rise, and clk index of each pop/underrun strobe
    logic rises[$];
    int   rd_times[$];
    int   un_times[$];
    logic prev_bclk = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            rises.delete(); rd_times.delete(); un_times.delete();
            prev_bclk <= 1'b0;
        end else begin
            if (bclk && !prev_bclk) rises.push_back(dacdat);
            if (fifo_rd) rd_times.push_back(n + 1);
            if (underrun) un_times.push_back(n + 1);
            prev_bclk <= bclk;
        end
    end

    function automatic logic [15:0] dec(input int s);
        logic [15:0] v = 'x;
        if (rises.size() >= s + 16) begin
            for (int i = 0; i < 16; i++) v = {v[14:0], rises[s + i]};
        end
        return v;
    endfunction

    task automatic reset_on();
        @(negedge clk);
        reset = 1'b1;
        mute = 1'b0;
        wr_ptr = rd_ptr;
        @(negedge clk);
    endtask

    task automatic reset_off();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] e;
        reset_on();
        n_assert++;
        if (outs !== 5'b0) begin n_fail++; $display("FAIL reset_outs got=%b exp=00000", outs); end
        reset_off();
        repeat (600) begin
            @(negedge clk); e = exp_outs(); n_assert++;
            if (outs !== e) begin n_fail++; $display("FAIL idle_cyc n=%0d got=%b exp=%b", n, outs, e); end
        end
        n_assert++;
        if (un_times.size() != 3 || un_times[0] != 8 || un_times[1] != 264 || un_times[2] != 520) begin
            n_fail++; $display("FAIL idle_underrun count=%0d first=%0d exp=3 at 8", un_times.size(),
                               (un_times.size() > 0) ? un_times[0] : -1);
        end
        n_assert++;
        if (rd_times.size() != 0) begin n_fail++; $display("FAIL idle_rd got=%0d exp=0", rd_times.size()); end
    endtask

    task automatic test_single();
        logic [4:0] e;
        reset_on();
        push(32'hA5A5_3C3C);
        reset_off();
        repeat (560) begin
            @(negedge clk); e = exp_outs(); n_assert++;
            if (outs !== e) begin n_fail++; $display("FAIL single_cyc n=%0d got=%b exp=%b", n, outs, e); end
        end
        n_assert++;
        if (rd_times.size() != 1 || rd_times[0] != 8) begin
            n_fail++; $display("FAIL single_pop count=%0d exp=1 at clk 8", rd_times.size());
        end
        n_assert++;
        if (rises[1] !== 1'b0) begin n_fail++; $display("FAIL single_delay got=%b exp=0", rises[1]); end
        n_assert++;
        if (dec(2) !== 16'hA5A5) begin n_fail++; $display("FAIL single_left got=%h exp=a5a5", dec(2)); end
        n_assert++;
        if (dec(18) !== 16'h3C3C) begin n_fail++; $display("FAIL single_right got=%h exp=3c3c", dec(18)); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] e;
        reset_on();
        push(32'hFFFF_0000);
        push(32'h0001_8000);
        reset_off();
        repeat (560) begin
            @(negedge clk); e = exp_outs(); n_assert++;
            if (outs !== e) begin n_fail++; $display("FAIL b2b_cyc n=%0d got=%b exp=%b", n, outs, e); end
        end
        n_assert++;
        if (rd_times.size() != 2 || rd_times[0] != 8 || rd_times[1] - rd_times[0] != 256) begin
            n_fail++; $display("FAIL b2b_pops count=%0d exp=2 spaced 256", rd_times.size());
        end
        n_assert++;
        if (dec(2) !== 16'hFFFF) begin n_fail++; $display("FAIL b2b_left0 got=%h exp=ffff", dec(2)); end
        n_assert++;
        if (rises[33] !== 1'b0) begin n_fail++; $display("FAIL b2b_delay got=%b exp=0", rises[33]); end
        n_assert++;
        if (dec(34) !== 16'h0001) begin n_fail++; $display("FAIL b2b_left1 got=%h exp=0001", dec(34)); end
        n_assert++;
        if (dec(50) !== 16'h8000) begin n_fail++; $display("FAIL b2b_right1 got=%h exp=8000", dec(50)); end
    endtask

    task automatic test_mute();
        logic [4:0] e;
        int ones;
        reset_on();
        mute = 1'b1;
        push(32'h1234_5678);
        reset_off();
        repeat (260) begin
            @(negedge clk); e = exp_outs(); n_assert++;
            if (outs !== e) begin n_fail++; $display("FAIL mute_cyc n=%0d got=%b exp=%b", n, outs, e); end
        end
        ones = 0;
        foreach (rises[i]) if (rises[i] !== 1'b0) ones++;
        n_assert++;
        if (ones != 0) begin n_fail++; $display("FAIL mute_data nonzero_bits=%0d exp=0", ones); end
        n_assert++;
        if (rd_times.size() != 1 || un_times.size() != 0 || !fifo_empty) begin
            n_fail++; $display("FAIL mute_pop pops=%0d underruns=%0d exp=1,0", rd_times.size(), un_times.size());
        end
        mute = 1'b0;
    endtask

    task automatic test_midreset();
        logic [4:0] e;
        reset_on();
        push(32'h1357_9BDF);
        push(32'hC0DE_4321);
        reset_off();
        repeat (93) begin
            @(negedge clk); e = exp_outs(); n_assert++;
            if (outs !== e) begin n_fail++; $display("FAIL mid_cyc n=%0d got=%b exp=%b", n, outs, e); end
        end
        #2 reset = 1'b1;
        #1 n_assert++;
        if (outs !== 5'b0) begin n_fail++; $display("FAIL mid_async got=%b exp=00000", outs); end
        reset_off();
        repeat (7) begin
            @(negedge clk); e = exp_outs(); n_assert++;
            if (outs !== e) begin n_fail++; $display("FAIL mid2_cyc n=%0d got=%b exp=%b", n, outs, e); end
        end
        n_assert++;
        if (fifo_rd !== 1'b1) begin n_fail++; $display("FAIL mid_rd_pre got=%b exp=1", fifo_rd); end
        #2 reset = 1'b1;
        #1 n_assert++;
        if (fifo_rd !== 1'b0) begin n_fail++; $display("FAIL mid_rd_async got=%b exp=0", fifo_rd); end
        reset_off();
        repeat (300) begin
            @(negedge clk); e = exp_outs(); n_assert++;
            if (outs !== e) begin n_fail++; $display("FAIL mid3_cyc n=%0d got=%b exp=%b", n, outs, e); end
        end
        n_assert++;
        if (rd_times.size() < 1 || rd_times[0] != 8) begin
            n_fail++; $display("FAIL mid_first_pop got=%0d exp=8", (rd_times.size() > 0) ? rd_times[0] : -1);
        end
        n_assert++;
        if (dec(2) !== 16'hC0DE) begin n_fail++; $display("FAIL mid_left got=%h exp=c0de", dec(2)); end
    endtask

    task automatic test_random();
        logic [4:0] e;
        reset_on();
        reset_off();
        repeat (1400) begin
            @(negedge clk); e = exp_outs(); n_assert++;
            if (outs !== e) begin n_fail++; $display("FAIL rand_cyc n=%0d got=%b exp=%b", n, outs, e); end
            if ((wr_ptr - rd_ptr) < 3 && $urandom_range(299, 0) == 0) push($urandom());
            mute = ($urandom_range(5, 0) == 0);
        end
        mute = 1'b0;
    endtask

`ifdef UNDERRUN_REPEAT_EN
    task automatic test_repeat();
        logic [4:0] e;
        reset_on();
        push(32'h7FFF_8001);
        reset_off();
        repeat (800) begin
            @(negedge clk); e = exp_outs(); n_assert++;
            if (outs !== e) begin n_fail++; $display("FAIL rep_cyc n=%0d got=%b exp=%b", n, outs, e); end
        end
        n_assert++;
        if (dec(34) !== 16'h7FFF || dec(50) !== 16'h8001) begin
            n_fail++; $display("FAIL rep_data got=%h/%h exp=7fff/8001", dec(34), dec(50));
        end
        n_assert++;
        if (un_times.size() != 3 || un_times[0] != 264 || rd_times.size() != 1) begin
            n_fail++; $display("FAIL rep_pulses underruns=%0d pops=%0d exp=3,1", un_times.size(), rd_times.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_mute();
        test_midreset();
        test_random();
`ifdef UNDERRUN_REPEAT_EN
        test_repeat();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
